// File: rtl/prog_encoder.sv
// ---------------------------------------------------------------------------
// prog_encoder
// Instruction encoder and program loader for the 4-bit-PC core.
// Takes instruction fields over a valid/ready stream, packs each bundle into
// the 32-bit decoder word {opcode, dst, src1, src0, imm}, and writes the words
// to consecutive instruction-memory addresses starting at 0.
//
// Optional feature macro: ENC_CHECK_EN
//   defined   -> illegal-field checking drives a sticky err flag
//   undefined -> no check logic, err is constant 0
//
// Ports
//   clk, rst_n      clock (rising edge) and asynchronous active-low reset
//   start           one-cycle pulse: clear address/count, enter LOAD
//   in_valid/ready  field-bundle handshake (in_ready from state and start only)
//   in_last         bundle is the final instruction of the program
//   in_opcode..imm  instruction fields
//   mem_we/addr/wdata  registered instruction-memory write port
//   count           words written since the last start
//   done            load complete, held until the next start
//   err             sticky illegal-field flag
// ---------------------------------------------------------------------------
module prog_encoder #(
    parameter int ADDR_W = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic              in_last,
    input  logic [3:0]        in_opcode,
    input  logic [3:0]        in_dst,
    input  logic [3:0]        in_src1,
    input  logic [3:0]        in_src0,
    input  logic [15:0]       in_imm,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [31:0]       mem_wdata,
    output logic [ADDR_W:0]   count,
    output logic              done,
    output logic              err
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LOAD = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t              state_q, state_d;
    logic [ADDR_W:0]     count_q, count_d;
    logic                mem_we_q, mem_we_d;
    logic [ADDR_W-1:0]   mem_addr_q, mem_addr_d;
    logic [31:0]         mem_wdata_q, mem_wdata_d;
    logic                transfer;
    logic [ADDR_W-1:0]   wptr;

    // The write pointer is the low bits of the word count; the FSM leaves
    // LOAD before the count could exceed the memory depth, so it never wraps.
    assign wptr     = count_q[ADDR_W-1:0];

    // start blocks the handshake so it always wins over a same-cycle beat.
    assign in_ready = (state_q == LOAD) && !start;
    assign transfer = in_valid && in_ready;

    always_comb begin
        state_d     = state_q;
        count_d     = count_q;
        mem_we_d    = 1'b0;
        mem_addr_d  = mem_addr_q;
        mem_wdata_d = mem_wdata_q;

        if (start) begin
            state_d = LOAD;
            count_d = '0;
        end else if (transfer) begin
            mem_we_d    = 1'b1;
            mem_addr_d  = wptr;
            mem_wdata_d = {in_opcode, in_dst, in_src1, in_src0, in_imm};
            count_d     = count_q + 1'b1;
            // Final instruction, or the last memory slot has just been used.
            if (in_last || (wptr == {ADDR_W{1'b1}})) begin
                state_d = DONE;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            count_q     <= '0;
            mem_we_q    <= 1'b0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
        end else begin
            state_q     <= state_d;
            count_q     <= count_d;
            mem_we_q    <= mem_we_d;
            mem_addr_q  <= mem_addr_d;
            mem_wdata_q <= mem_wdata_d;
        end
    end

    assign mem_we    = mem_we_q;
    assign mem_addr  = mem_addr_q;
    assign mem_wdata = mem_wdata_q;
    assign count     = count_q;
    assign done      = (state_q == DONE);

`ifdef ENC_CHECK_EN
    logic err_q, err_d;
    logic illegal;

    // Only ALU (0) and jump (1) exist; a jump target must fit the 4-bit PC.
    assign illegal = (in_opcode > 4'd1) ||
                     ((in_opcode == 4'd1) && (in_imm[15:4] != 12'd0));

    always_comb begin
        err_d = err_q;
        if (start) begin
            err_d = 1'b0;
        end else if (transfer && illegal) begin
            err_d = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            err_q <= 1'b0;
        end else begin
            err_q <= err_d;
        end
    end

    assign err = err_q;
`else
    assign err = 1'b0;
`endif

endmodule
